// File: rtl/fea_pro_pkg.sv
// fea_pro shared types: record layout, window type and the corner-test helper.
// Imported by fea_window_3x3 and fea_pro.
package fea_pro_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;
  localparam int DESC_W  = 128;
  localparam int REC_W   = 148;

  localparam int WIN_LSB = 0;
  localparam int WIN_W   = 72;
  localparam int CEN_LSB = 72;
  localparam int CEN_W   = 8;
  localparam int PAD_LSB = 80;
  localparam int PAD_W   = DESC_W - PAD_LSB;

  localparam int ROW_LSB = 128;
  localparam int COL_LSB = 138;

  // p00 lands in the top byte when flattened
  typedef logic [0:2][0:2][PIX_W-1:0] win_t;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic differs(
    input logic [PIX_W-1:0] n,
    input logic [PIX_W-1:0] c,
    input logic [PIX_W-1:0] thr
  );
    logic [PIX_W:0] n9;
    logic [PIX_W:0] c9;
    logic [PIX_W:0] t9;
    n9 = {1'b0, n};
    c9 = {1'b0, c};
    t9 = {1'b0, thr};
    return (n9 > c9 + t9) || (n9 + t9 < c9);
  endfunction

endpackage

// File: rtl/fea_window_3x3.sv
// Two line buffers plus a 3x3 pixel window.
// A new column enters on the right on every enabled cycle.
module fea_window_3x3
  import fea_pro_pkg::*;
#(
  parameter int Img_Width = 120,
  localparam int AW = (Img_Width > 1) ? $clog2(Img_Width) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] pix,
  output win_t             win
);

  logic [PIX_W-1:0] lb0 [Img_Width];
  logic [PIX_W-1:0] lb1 [Img_Width];
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] mid;

  assign top = lb1[addr];
  assign mid = lb0[addr];

  // line storage is never cleared; stale rows are masked by the row counter
  always_ff @(posedge clk) begin
    if (en) begin
      lb1[addr] <= mid;
      lb0[addr] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else if (en) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= top;
      win[1][2] <= mid;
      win[2][2] <= pix;
    end
  end

endmodule

// File: rtl/fea_pro.sv
// Streaming FAST-lite corner detector with census/window descriptor.
// Optional per-frame feature statistics under FEA_PRO_STATS_EN.
module fea_pro
  import fea_pro_pkg::*;
#(
  parameter int Img_Height = 100,
  parameter int Img_Width  = 120,
  parameter int THRESH     = 20,
  parameter int N_MIN      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] img_din,
  input  logic             img_din_valid,
  output logic             dout_valid,
  output logic             feature_flag,
  output logic [REC_W-1:0] des_coor
`ifdef FEA_PRO_STATS_EN
  ,
  output logic [15:0]      frame_feat_cnt,
  output logic             frame_done
`endif
);

  localparam int AW = (Img_Width > 1) ? $clog2(Img_Width) : 1;

  localparam coord_t LAST_COL = coord_t'(Img_Width - 1);
  localparam coord_t LAST_ROW = coord_t'(Img_Height - 1);
  localparam coord_t END_COL  = coord_t'(Img_Width - 2);
  localparam coord_t END_ROW  = coord_t'(Img_Height - 2);
  localparam coord_t TWO      = coord_t'(2);

  localparam logic [PIX_W-1:0] THR  = PIX_W'(THRESH);
  localparam logic [3:0]       NMIN = 4'(N_MIN);

  coord_t col;
  coord_t row;
  coord_t pend_col;
  coord_t pend_row;
  logic   pend;
  logic   eval;

  win_t win;

  logic [7:0][PIX_W-1:0] nb;
  logic [CEN_W-1:0]      cen;
  logic [3:0]            ndiff;
  logic                  corner;
  logic [DESC_W-1:0]     desc;

  assign eval = img_din_valid && (row >= TWO) && (col >= TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (img_din_valid) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // centre of the window is one row up and one column left of the input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= 1'b0;
      pend_col <= '0;
      pend_row <= '0;
    end else begin
      pend <= eval;
      if (eval) begin
        pend_col <= col - 1'b1;
        pend_row <= row - 1'b1;
      end
    end
  end

  fea_window_3x3 #(
    .Img_Width(Img_Width)
  ) u_win (
    .clk (clk),
    .rst (rst),
    .en  (img_din_valid),
    .addr(col[AW-1:0]),
    .pix (img_din),
    .win (win)
  );

  assign nb = {
    win[0][0], win[0][1], win[0][2],
    win[1][0],            win[1][2],
    win[2][0], win[2][1], win[2][2]
  };

  always_comb begin
    cen   = '0;
    ndiff = '0;
    for (int i = 0; i < 8; i++) begin
      cen[i] = nb[i] < win[1][1];
      ndiff  = ndiff + {3'b000, differs(nb[i], win[1][1], THR)};
    end
  end

  assign corner = ndiff >= NMIN;
  assign desc   = {{PAD_W{1'b0}}, cen, win};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid   <= 1'b0;
      feature_flag <= 1'b0;
      des_coor     <= '0;
    end else begin
      dout_valid   <= pend;
      feature_flag <= pend && corner;
      if (pend) begin
        des_coor <= {pend_col, pend_row, desc};
      end
    end
  end

`ifdef FEA_PRO_STATS_EN
  logic [15:0] feat_cnt;
  logic [15:0] cnt_nxt;
  logic        last_rec;

  assign last_rec = pend && (pend_row == END_ROW) && (pend_col == END_COL);

  always_comb begin
    cnt_nxt = feat_cnt;
    if (pend && corner && (feat_cnt != 16'hFFFF)) begin
      cnt_nxt = feat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feat_cnt       <= '0;
      frame_feat_cnt <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= last_rec;
      if (last_rec) begin
        frame_feat_cnt <= cnt_nxt;
        feat_cnt       <= '0;
      end else begin
        feat_cnt <= cnt_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fea_pro.sv
// Randomized scoreboard bench for fea_pro.
// The reference model works directly on a stored frame image.
module tb_fea_pro;

  localparam int H  = 100;
  localparam int W  = 120;
  localparam int T  = 20;
  localparam int NM = 6;
  localparam int NREC = (H - 2) * (W - 2);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   img_din = '0;
  logic         img_din_valid = 1'b0;
  logic         dout_valid;
  logic         feature_flag;
  logic [147:0] des_coor;
`ifdef FEA_PRO_STATS_EN
  logic [15:0]  frame_feat_cnt;
  logic         frame_done;
  int           model_feat = 0;
`endif

  fea_pro #(
    .Img_Height(H),
    .Img_Width (W),
    .THRESH    (T),
    .N_MIN     (NM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .img_din      (img_din),
    .img_din_valid(img_din_valid),
    .dout_valid   (dout_valid),
    .feature_flag (feature_flag),
    .des_coor     (des_coor)
`ifdef FEA_PRO_STATS_EN
    ,
    .frame_feat_cnt(frame_feat_cnt),
    .frame_done    (frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         flag;
    logic [147:0] rec;
  } exp_t;

  int           n_chk = 0;
  int           n_fail = 0;
  exp_t         q[$];
  logic [7:0]   img [H][W];
  int           rec_cnt = 0;
  int           flag_cnt = 0;
  logic [147:0] last_flag_rec = '0;
  bit           flag_at [int];
  logic         acc1 = 1'b0;
  logic         acc2 = 1'b0;

  task automatic check(input string name, input logic [147:0] act,
                       input logic [147:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int r, input int c);
    exp_t       e;
    int         ctr;
    int         v;
    int         nd;
    int         k;
    logic [7:0] cen;
    logic [71:0] win;
    ctr = int'(img[r][c]);
    nd  = 0;
    k   = 7;
    cen = '0;
    win = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        v   = int'(img[r+dr][c+dc]);
        win = {win[63:0], 8'(v)};
        if (dr != 0 || dc != 0) begin
          if (v > ctr + T || v + T < ctr) nd++;
          cen[k] = (v < ctr);
          k--;
        end
      end
    end
    e.flag = (nd >= NM);
    e.rec  = {10'(c), 10'(r), 48'd0, cen, win};
    return e;
  endfunction

  task automatic fill(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(v);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'($urandom_range(255, 0));
  endtask

  task automatic send_pix(input int r, input int c, input int gap);
    while (gap > 0 && int'($urandom_range(99, 0)) < gap) begin
      img_din_valid = 1'b0;
      @(posedge clk); #1;
    end
    img_din       = img[r][c];
    img_din_valid = 1'b1;
    if (r >= 2 && c >= 2) q.push_back(model(r - 1, c - 1));
    @(posedge clk); #1;
    img_din_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++)
        send_pix(r, c, gap);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 148'(q.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout_valid"}, {147'd0, dout_valid}, '0);
    check({tag, "_feature_flag"}, {147'd0, feature_flag}, '0);
    check({tag, "_des_coor"}, des_coor, '0);
  endtask

  always @(posedge clk) begin
    acc1 <= img_din_valid && rst;
    acc2 <= acc1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
`ifdef FEA_PRO_STATS_EN
      model_feat = 0;
`endif
    end else begin
      check("flag_without_valid", {147'd0, feature_flag & ~dout_valid}, '0);
      if (dout_valid) begin
        check("valid_without_accept", {147'd0, acc2}, 148'd1);
        if (q.size() == 0) begin
          check("unexpected_record", {147'd0, dout_valid}, '0);
        end else begin
          e = q.pop_front();
          check("record", des_coor, e.rec);
          check("corner_flag", {147'd0, feature_flag}, {147'd0, e.flag});
          rec_cnt++;
          if (feature_flag) begin
            flag_cnt++;
            last_flag_rec = des_coor;
          end
          flag_at[int'(des_coor[137:128]) * W + int'(des_coor[147:138])] = feature_flag;
`ifdef FEA_PRO_STATS_EN
          if (e.flag) model_feat++;
          if (e.rec[137:128] == 10'(H - 2) && e.rec[147:138] == 10'(W - 2)) begin
            check("frame_done", {147'd0, frame_done}, 148'd1);
            check("frame_feat_cnt", {132'd0, frame_feat_cnt}, 148'(model_feat));
            model_feat = 0;
          end else begin
            check("frame_done_idle", {147'd0, frame_done}, '0);
          end
`endif
        end
      end
    end
  end

  initial begin
    int c0;
    int f0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // flat frame
    fill(100);
    c0 = rec_cnt; f0 = flag_cnt;
    send_frame(0, H);
    drain();
    check("flat_count", 148'(rec_cnt - c0), 148'(NREC));
    check("flat_flags", 148'(flag_cnt - f0), '0);
    check("flat_last_coord", {128'd0, des_coor[147:128]}, {128'd0, 10'd118, 10'd98});

    // single bright pixel with ~50% input gaps
    fill(0);
    img[50][60] = 8'hFF;
    c0 = rec_cnt; f0 = flag_cnt;
    send_frame(50, H);
    drain();
    check("single_count", 148'(rec_cnt - c0), 148'(NREC));
    check("single_flags", 148'(flag_cnt - f0), 148'd1);
    check("single_coord", {128'd0, last_flag_rec[147:128]}, {128'd0, 10'd60, 10'd50});
    check("single_pad", {100'd0, last_flag_rec[127:80]}, '0);
    check("single_census", {140'd0, last_flag_rec[79:72]}, {140'd0, 8'hFF});
    check("single_window", {76'd0, last_flag_rec[71:0]}, {76'd0, 72'hFF << 32});

    // threshold boundary patches on a background of 100
    fill(100);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) img[20+dr][20+dc] = 8'd120;
    img[19][59] = 8'd121; img[19][60] = 8'd121; img[19][61] = 8'd121;
    img[20][59] = 8'd121; img[20][61] = 8'd121; img[21][59] = 8'd121;
    img[59][59] = 8'd121; img[59][60] = 8'd121; img[59][61] = 8'd121;
    img[60][59] = 8'd121; img[60][61] = 8'd121;
    c0 = rec_cnt;
    send_frame(0, H);
    drain();
    check("thr_count", 148'(rec_cnt - c0), 148'(NREC));
    check("thr_equal_no_corner", {147'd0, flag_at[20*W+20]}, '0);
    check("thr_six_corner", {147'd0, flag_at[20*W+60]}, 148'd1);
    check("thr_five_no_corner", {147'd0, flag_at[60*W+60]}, '0);

    // idle gap, then a random frame
    repeat (1000) @(posedge clk);
    #1;
    fill_rand();
    c0 = rec_cnt;
    send_frame(0, H);
    drain();
    check("rand_count", 148'(rec_cnt - c0), 148'(NREC));

    // partial frame, reset at row 40, then a full frame
    fill_rand();
    send_frame(0, 41);
    drain();
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    img_din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midreset_valid");
    img_din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    fill_rand();
    c0 = rec_cnt;
    send_frame(0, H);
    drain();
    check("post_reset_count", 148'(rec_cnt - c0), 148'(NREC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
